// File: rtl/entrada_digito.sv
// Debounced digit entry: synchronizes a bouncing "insert" button and 4-bit switches, emits one strobe per press.
// Optional macro ENTRADA_DIGITO_BCD_CHECK_EN rejects captures above 9 with erro instead of valido.
module entrada_digito #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere_raw,
  input  logic [3:0] numero_raw,
  output logic [3:0] digito,
  output logic       valido,
  output logic       erro,
  output logic       ocupado,
  output logic [1:0] estado
);

  // Handshake: valido/erro are single-cycle strobes with no ready; the consumer
  // samples digito while valido=1, and digito holds until the next accepted capture.

  typedef enum logic [1:0] {
    SOLTO        = 2'd0,
    FILTRA_PRESS = 2'd1,
    PRESSIONADO  = 2'd2,
    FILTRA_SOLTA = 2'd3
  } estado_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic       ins_m, ins_s;
  logic [3:0] num_m, num_s;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digito_d;
  logic          valido_d, erro_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_m <= 1'b0;
      ins_s <= 1'b0;
      num_m <= 4'h0;
      num_s <= 4'h0;
    end else begin
      ins_m <= insere_raw;
      ins_s <= ins_m;
      num_m <= numero_raw;
      num_s <= num_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SOLTO;
      cnt_q   <= '0;
      digito  <= 4'h0;
      valido  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digito  <= digito_d;
      valido  <= valido_d;
      erro    <= erro_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digito_d = digito;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    case (state_q)
      SOLTO: begin
        if (ins_s) state_d = FILTRA_PRESS;
      end
      FILTRA_PRESS: begin
        if (!ins_s) begin
          state_d = SOLTO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSIONADO;
`ifdef ENTRADA_DIGITO_BCD_CHECK_EN
          if (num_s > 4'd9) begin
            erro_d = 1'b1;
          end else begin
            digito_d = num_s;
            valido_d = 1'b1;
          end
`else
          digito_d = num_s;
          valido_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!ins_s) state_d = FILTRA_SOLTA;
      end
      FILTRA_SOLTA: begin
        if (ins_s) begin
          state_d = PRESSIONADO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = SOLTO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SOLTO;
    endcase
    // every transition restarts the stability window
    if (state_d != state_q) cnt_d = '0;
  end

  assign ocupado = (state_q != SOLTO);
  assign estado  = state_q;

endmodule

// File: tb/tb_entrada_digito.sv
// Directed bench for entrada_digito with DEBOUNCE_CYCLES=4; expected values are hand-computed.
module tb_entrada_digito;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere_raw;
  logic [3:0] numero_raw;
  logic [3:0] digito;
  logic       valido;
  logic       erro;
  logic       ocupado;
  logic [1:0] estado;

  int total = 0;
  int bad = 0;
  int edges = 0;
  int n_valido = 0;
  int n_erro = 0;
  int n_both = 0;
  int last_valido_edge = -1;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  entrada_digito #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .insere_raw (insere_raw),
    .numero_raw (numero_raw),
    .digito     (digito),
    .valido     (valido),
    .erro       (erro),
    .ocupado    (ocupado),
    .estado     (estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  // strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (valido) begin
      n_valido++;
      last_valido_edge = edges;
      got_q.push_back(digito);
    end
    if (erro) n_erro++;
    if (valido && erro) n_both++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_valido = 0;
    n_erro = 0;
    last_valido_edge = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_digit(input logic [3:0] d);
    numero_raw = d;
    tick(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    insere_raw = 1'b1;
    numero_raw = 4'd7;
    tick(3);
    total++; if (digito !== 4'h0) begin bad++; $display("FAIL reset_digito got=%0d exp=0", digito); end
    total++; if (valido !== 1'b0) begin bad++; $display("FAIL reset_valido got=%b exp=0", valido); end
    total++; if (erro !== 1'b0) begin bad++; $display("FAIL reset_erro got=%b exp=0", erro); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    total++; if (estado !== 2'd0) begin bad++; $display("FAIL reset_estado got=%0d exp=0", estado); end
    insere_raw = 1'b0;
    numero_raw = 4'd0;
    tick(1);
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_clean_press();
    int e0;
    set_digit(4'd5);
    clear_mon();
    insere_raw = 1'b1;
    e0 = edges;
    tick(20);
    total++; if (n_valido !== 1) begin bad++; $display("FAIL clean_count got=%0d exp=1", n_valido); end
    total++; if (last_valido_edge !== e0 + 7) begin bad++; $display("FAIL clean_latency got=%0d exp=%0d", last_valido_edge, e0 + 7); end
    total++; if (digito !== 4'd5) begin bad++; $display("FAIL clean_digito got=%0d exp=5", digito); end
    total++; if (n_erro !== 0) begin bad++; $display("FAIL clean_erro got=%0d exp=0", n_erro); end
    insere_raw = 1'b0;
    tick(6);
    total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL clean_busy_hold got=%b exp=1", ocupado); end
    tick(1);
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL clean_busy_drop got=%b exp=0", ocupado); end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10101;
    set_digit(4'd3);
    clear_mon();
    for (int i = 4; i >= 1; i--) begin
      insere_raw = pat[i];
      tick(1);
    end
    insere_raw = pat[0];
    tick(1);
    total++; if (n_valido !== 0) begin bad++; $display("FAIL bounce_quiet got=%0d exp=0", n_valido); end
    tick(15);
    total++; if (n_valido !== 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", n_valido); end
    total++; if (digito !== 4'd3) begin bad++; $display("FAIL bounce_digito got=%0d exp=3", digito); end
    insere_raw = 1'b0;
    tick(10);
    total++; if (estado !== 2'd0) begin bad++; $display("FAIL bounce_idle got=%0d exp=0", estado); end
  endtask

  task automatic test_glitch();
    set_digit(4'd6);
    clear_mon();
    insere_raw = 1'b1;
    tick(3);
    insere_raw = 1'b0;
    tick(10);
    total++; if (n_valido !== 0) begin bad++; $display("FAIL glitch_valido got=%0d exp=0", n_valido); end
    total++; if (n_erro !== 0) begin bad++; $display("FAIL glitch_erro got=%0d exp=0", n_erro); end
    total++; if (estado !== 2'd0) begin bad++; $display("FAIL glitch_estado got=%0d exp=0", estado); end
    total++; if (digito !== 4'd3) begin bad++; $display("FAIL glitch_digito got=%0d exp=3", digito); end
  endtask

  task automatic test_release_bounce();
    set_digit(4'd2);
    clear_mon();
    insere_raw = 1'b1;
    tick(12);
    numero_raw = 4'd9;
    insere_raw = 1'b0; tick(1);
    insere_raw = 1'b1; tick(3);
    insere_raw = 1'b0; tick(1);
    insere_raw = 1'b1; tick(6);
    total++; if (n_valido !== 1) begin bad++; $display("FAIL relbounce_count got=%0d exp=1", n_valido); end
    total++; if (digito !== 4'd2) begin bad++; $display("FAIL relbounce_digito got=%0d exp=2", digito); end
    total++; if (estado !== 2'd2) begin bad++; $display("FAIL relbounce_held got=%0d exp=2", estado); end
    insere_raw = 1'b0;
    tick(10);
    total++; if (n_valido !== 1) begin bad++; $display("FAIL relbounce_final got=%0d exp=1", n_valido); end
    total++; if (estado !== 2'd0) begin bad++; $display("FAIL relbounce_idle got=%0d exp=0", estado); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq[6];
    seq = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      set_digit(seq[i]);
      exp_q.push_back(seq[i]);
      insere_raw = 1'b1;
      tick(10);
      insere_raw = 1'b0;
      tick(10);
    end
    total++; if (got_q.size() !== 6) begin bad++; $display("FAIL seq_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL seq_digit%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    total++; if (digito !== 4'd1) begin bad++; $display("FAIL seq_hold got=%0d exp=1", digito); end
  endtask

  task automatic test_reset_capture();
    int e0, e1;
    set_digit(4'd4);
    clear_mon();
    insere_raw = 1'b1;
    e0 = edges;
    tick(6);
    reset = 1'b1;
    tick(1);
    total++; if (valido !== 1'b0) begin bad++; $display("FAIL rstcap_valido got=%b exp=0", valido); end
    total++; if (digito !== 4'h0) begin bad++; $display("FAIL rstcap_digito got=%0d exp=0", digito); end
    total++; if (n_valido !== 0) begin bad++; $display("FAIL rstcap_count got=%0d exp=0", n_valido); end
    reset = 1'b0;
    e1 = edges;
    tick(12);
    total++; if (n_valido !== 1) begin bad++; $display("FAIL rstheld_count got=%0d exp=1", n_valido); end
    total++; if (last_valido_edge !== e1 + 7) begin bad++; $display("FAIL rstheld_latency got=%0d exp=%0d", last_valido_edge, e1 + 7); end
    total++; if (digito !== 4'd4) begin bad++; $display("FAIL rstheld_digito got=%0d exp=4", digito); end
    total++; if (e1 !== e0 + 7) begin bad++; $display("FAIL rstcap_edge got=%0d exp=%0d", e1, e0 + 7); end
    insere_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_bcd();
    set_digit(4'd12);
    clear_mon();
    insere_raw = 1'b1;
    tick(12);
    insere_raw = 1'b0;
    tick(10);
`ifdef ENTRADA_DIGITO_BCD_CHECK_EN
    total++; if (n_erro !== 1) begin bad++; $display("FAIL bcd_erro got=%0d exp=1", n_erro); end
    total++; if (n_valido !== 0) begin bad++; $display("FAIL bcd_valido got=%0d exp=0", n_valido); end
    total++; if (digito !== 4'd4) begin bad++; $display("FAIL bcd_digito got=%0d exp=4", digito); end
`else
    total++; if (n_erro !== 0) begin bad++; $display("FAIL bcd_erro got=%0d exp=0", n_erro); end
    total++; if (n_valido !== 1) begin bad++; $display("FAIL bcd_valido got=%0d exp=1", n_valido); end
    total++; if (digito !== 4'd12) begin bad++; $display("FAIL bcd_digito got=%0d exp=12", digito); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    insere_raw = 1'b0;
    numero_raw = 4'd0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_release_bounce();
    test_back_to_back();
    test_reset_capture();
    test_bcd();
    total++; if (n_both !== 0) begin bad++; $display("FAIL both_strobes got=%0d exp=0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/entrada_digito.md
ENTRADA_DIGITO -- requirements
Module: entrada_digito

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles of a stable level that are needed to accept a press or a release (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port insere_raw, input, 1 bit: asynchronous "insert" pushbutton, active-high, bouncing.
REQ-005 The block SHALL have port numero_raw, input, 4 bits: asynchronous digit switches, binary.
REQ-006 The block SHALL have port digito, output, 4 bits: last accepted digit, registered.
REQ-007 The block SHALL have port valido, output, 1 bit: one-cycle strobe marking a newly accepted digit on digito.
REQ-008 The block SHALL have port erro, output, 1 bit: one-cycle strobe marking a rejected digit (see Configuration).
REQ-009 The block SHALL have port ocupado, output, 1 bit: high whenever the FSM is not in SOLTO.

Function
REQ-010 insere_raw and numero_raw SHALL each pass through a 2-flop synchronizer; all logic downstream SHALL use only the second-stage values (ins_s, num_s).
REQ-011 The FSM SHALL have four states: SOLTO, FILTRA_PRESS, PRESSIONADO and FILTRA_SOLTA.
REQ-012 The debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL clear to 0 on every state change.
REQ-013 In SOLTO, the FSM SHALL go to FILTRA_PRESS when ins_s=1 and SHALL otherwise stay in SOLTO.
REQ-014 In FILTRA_PRESS, ins_s=0 SHALL return the FSM to SOLTO with no strobe.
REQ-015 In FILTRA_PRESS, when ins_s=1 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSIONADO and capture num_s; otherwise cnt SHALL increment.
REQ-016 In PRESSIONADO, the FSM SHALL go to FILTRA_SOLTA when ins_s=0 and SHALL otherwise hold.
REQ-017 In FILTRA_SOLTA, ins_s=1 SHALL return the FSM to PRESSIONADO with no new strobe and no capture.
REQ-018 In FILTRA_SOLTA, when ins_s=0 and cnt=DEBOUNCE_CYCLES-1, the FSM SHALL go to SOLTO; otherwise cnt SHALL increment.
REQ-019 For a capture, the same edge that enters PRESSIONADO SHALL load digito and set valido (or erro), and the strobe SHALL clear on the next edge.
REQ-020 Latency: if edge 1 is the first edge that samples insere_raw high and the input is then held, the strobe SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3.
REQ-021 There SHALL be exactly one strobe per accepted press, however long the button is held; there is no auto-repeat.
REQ-022 valido and erro SHALL never be high in the same cycle.
REQ-023 The consumer has no backpressure and SHALL sample digito while valido=1; digito SHALL hold its value until the next accepted capture.
REQ-024 A changing numero_raw while the button is held SHALL be ignored; only the value of num_s at the capture edge counts.

Reset
REQ-025 reset=1 at a rising edge SHALL force: both synchronizers to 0, state=SOLTO, cnt=0, digito=4'h0, valido=0, erro=0, ocupado=0.
REQ-026 reset SHALL take priority over every transition, including a capture on the same edge, which SHALL be discarded.
REQ-027 A button still held when reset is released SHALL be treated as a new press and SHALL yield one strobe after the full latency of REQ-020.

Configuration
REQ-028 Macro ENTRADA_DIGITO_BCD_CHECK_EN, when defined, SHALL make a capture with num_s > 9 pulse erro instead of valido and leave digito unchanged.
REQ-029 When ENTRADA_DIGITO_BCD_CHECK_EN is defined, captures with num_s 0..9 SHALL behave as in REQ-019.
REQ-030 Without ENTRADA_DIGITO_BCD_CHECK_EN, every value 0..15 SHALL be accepted with valido, and erro SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Clean press test: numero_raw=5, insere_raw held high for 20 cycles then low -> one valido, in the cycle after edge 7, with digito=5; ocupado returns to 0 about 4+2 cycles after release.
REQ-032 Bounce test: insere_raw toggles 1,0,1,0,1 every cycle, then is held high -> no strobe during the bounce, then exactly one valido with the correct digit.
REQ-033 Glitch test: insere_raw high for 3 cycles then low -> no valido, no erro, FSM back in SOLTO.
REQ-034 Release-bounce test: held press, then two 1-cycle low dips shorter than 4 cycles -> no second valido and digito unchanged.
REQ-035 Sequence test: press 5,9,0,9,8,1 in turn -> six valido pulses, with digito following 5,9,0,9,8,1.
REQ-036 Reset and check test: reset asserted the cycle before the capture edge -> no strobe and digito=0. With the macro defined, numero_raw=12 -> erro pulse and digito unchanged; without the macro, valido with digito=12.
